// File: rtl/invol_arbiter_pkg.sv
// Shared definitions for the involuntary-response arbiter and its neighbours.
// Holds the arbiter state encoding and the default param word width.
package invol_arbiter_pkg;

    localparam int INVOL_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_ACTIVE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/invol_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Rotates the request vector, priority-encodes it, then rotates the result back.
module invol_arbiter_rr_pick #(
    parameter int NUNITS = 4,
    localparam int IW = $clog2(NUNITS)
) (
    input  logic [NUNITS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NUNITS-1:0] onehot,
    output logic [IW-1:0]     index,
    output logic              valid
);

    logic [2*NUNITS-1:0] doubled;
    logic [NUNITS-1:0]   rotated;
    logic [IW-1:0]       offset;
    int                  sum;

    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NUNITS-1:0];
        offset  = '0;
        valid   = 1'b0;
        for (int i = NUNITS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IW'(i);
                valid  = 1'b1;
            end
        end
        // Explicit wrap so non-power-of-two NUNITS never yields an out-of-range index.
        sum = int'(ptr) + int'(offset);
        if (sum >= NUNITS) sum = sum - NUNITS;
        index  = IW'(sum);
        onehot = valid ? (NUNITS'(1) << index) : '0;
    end

endmodule

// File: rtl/invol_arbiter.sv
// Round-robin owner of the shared involuntary-response path (param stream to the framer).
// Grants only while no host command runs; holds ownership until done or watchdog expiry.
module invol_arbiter
    import invol_arbiter_pkg::*;
#(
    parameter int NUNITS       = 4,
    parameter int DATA_W       = INVOL_DATA_W,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUNITS-1:0]        unit_req,
    output logic [NUNITS-1:0]        unit_grant,
    input  logic [NUNITS-1:0]        unit_done,
    input  logic [NUNITS*DATA_W-1:0] unit_param_data,
    input  logic [NUNITS-1:0]        unit_param_write,
    input  logic                     cmd_busy,
    output logic                     invol_active,
    output logic [DATA_W-1:0]        param_data,
    output logic                     param_write,
    output logic                     invol_done,
    output logic                     timeout_err,
    output arb_state_t               dbg_state
);

    localparam int IW = $clog2(NUNITS);

    // Handshake: a unit holds unit_req until it sees its one-cycle unit_grant, then streams
    // param words (one per unit_param_write) and ends with a unit_done pulse; anything it
    // sends while not the owner is dropped and must be re-requested.

    arb_state_t              state, state_next;
    logic [IW-1:0]           owner, owner_next;
    logic [IW-1:0]           ptr, ptr_next, owner_plus1;
    logic [TIMEOUT_BITS-1:0] wdog, wdog_next, wdog_inc;
    logic [NUNITS-1:0]       grant_next, pick_onehot;
    logic [IW-1:0]           pick_index;
    logic                    pick_valid;
    logic                    active_next, pwrite_next, done_next, tout_next;
    logic [DATA_W-1:0]       pdata_next, owner_data;

    invol_arbiter_rr_pick #(.NUNITS(NUNITS)) u_rr_pick (
        .req    (unit_req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .valid  (pick_valid)
    );

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (owner == IW'(i)) owner_data = unit_param_data[i*DATA_W +: DATA_W];
        end
    end

    assign owner_plus1 = (owner == IW'(NUNITS - 1)) ? '0 : owner + 1'b1;
    assign wdog_inc    = wdog + 1'b1;
    assign dbg_state   = state;

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        ptr_next    = ptr;
        wdog_next   = wdog;
        grant_next  = '0;
        active_next = invol_active;
        pdata_next  = param_data;
        pwrite_next = 1'b0;
        done_next   = 1'b0;
        tout_next   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!cmd_busy && pick_valid) begin
                    owner_next  = pick_index;
                    grant_next  = pick_onehot;
                    active_next = 1'b1;
                    state_next  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                wdog_next  = '0;
                state_next = ARB_ACTIVE;
            end
            ARB_ACTIVE: begin
                pdata_next  = owner_data;
                pwrite_next = unit_param_write[owner];
                if (unit_done[owner]) begin
                    done_next   = 1'b1;
                    active_next = 1'b0;
                    ptr_next    = owner_plus1;
                    state_next  = ARB_IDLE;
                end else if (wdog_inc == '1) begin
                    // Counter reaching all-ones marks 2**TIMEOUT_BITS-1 silent ACTIVE cycles.
                    tout_next   = 1'b1;
                    done_next   = 1'b1;
                    pwrite_next = 1'b0;
                    active_next = 1'b0;
                    ptr_next    = owner_plus1;
                    state_next  = ARB_IDLE;
                end else begin
                    wdog_next = wdog_inc;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARB_IDLE;
            owner        <= '0;
            ptr          <= '0;
            wdog         <= '0;
            unit_grant   <= '0;
            invol_active <= 1'b0;
            param_data   <= '0;
            param_write  <= 1'b0;
            invol_done   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_next;
            owner        <= owner_next;
            ptr          <= ptr_next;
            wdog         <= wdog_next;
            unit_grant   <= grant_next;
            invol_active <= active_next;
            param_data   <= pdata_next;
            param_write  <= pwrite_next;
            invol_done   <= done_next;
            timeout_err  <= tout_next;
        end
    end

endmodule
